// File: rtl/pipelined_riscv_control_hazard_if.sv
// Status and control bundle between the pipelined RISC-V datapath and its
// control/hazard unit. The datapath drives status (master); the control unit drives control (slave).
interface pipelined_riscv_control_hazard_if;
  // D-stage instruction fields and E-stage ALU flag
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zeroE;
  // Register specifiers per stage
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  // Control outputs
  logic       PCSrcE;
  logic [1:0] ImmSrcD;
  logic       ALUSrcE;
  logic [2:0] ALUControlE;
  logic       MemWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;
  // Hazard outputs
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output opcode, func3, func7, zeroE,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  PCSrcE, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, RegWriteW, ResultSrcW,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  opcode, func3, func7, zeroE,
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output PCSrcE, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, RegWriteW, ResultSrcW,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/pipelined_riscv_control_hazard.sv
// Control decode plus hazard unit for the 5-stage RISC-V pipeline: decodes in D, carries
// control through D/E, E/M and M/W, and produces stall, flush, forward and branch-taken signals.
module pipelined_riscv_control_hazard #(
  parameter bit ENABLE_FORWARDING = 1'b1
) (
  input logic                             clock,
  input logic                             reset,
  pipelined_riscv_control_hazard_if.slave bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] func3;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_e_t;

  // D-stage decode
  ctrl_e_t    dec;
  logic [1:0] dec_imm_src;
  logic       dec_arith;

  // Pipeline registers
  ctrl_e_t    ctrl_e_q, ctrl_e_d;
  logic       reg_write_m_q, reg_write_m_d;
  logic [1:0] result_src_m_q, result_src_m_d;
  logic       mem_write_m_q, mem_write_m_d;
  logic       reg_write_w_q, reg_write_w_d;
  logic [1:0] result_src_w_q, result_src_w_d;

  // Hazard logic
  logic       branch_cond;
  logic       pc_src;
  logic       d_uses_e;
  logic       d_uses_m;
  logic       lw_stall;
  logic       raw_stall;
  logic       stall;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Only func7[5] distinguishes sub from add; the rest of func7 is don't-care here.
  logic unused_func7;
  assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

  always_comb begin
    dec         = '0;
    dec_imm_src = 2'b00;
    dec_arith   = 1'b0;
    case (bus.opcode)
      OpLoad: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = ResMem;
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_imm_src   = 2'b01;
      end
      OpRType: begin
        dec.reg_write = 1'b1;
        dec_arith     = 1'b1;
      end
      OpIAlu: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_arith     = 1'b1;
      end
      OpBranch: begin
        dec.branch = 1'b1;
        dec_imm_src = 2'b10;
      end
      OpJal: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = ResPc4;
        dec_imm_src    = 2'b11;
      end
      default: ;
    endcase

    dec.func3       = dec.branch ? bus.func3 : 3'b000;
    dec.alu_control = AluAdd;
    if (dec.branch) begin
      dec.alu_control = AluSub;
    end else if (dec_arith) begin
      case (bus.func3)
        // addi never subtracts: func7 is part of the immediate for I-ALU.
        3'b000:  dec.alu_control = (bus.opcode == OpRType && bus.func7[5]) ? AluSub : AluAdd;
        3'b111:  dec.alu_control = AluAnd;
        3'b110:  dec.alu_control = AluOr;
        3'b010:  dec.alu_control = AluSlt;
        default: dec.alu_control = AluAdd;
      endcase
    end
  end

  always_comb begin
    branch_cond = 1'b0;
    case (ctrl_e_q.func3)
      3'b000:  branch_cond = bus.zeroE;
      3'b001:  branch_cond = ~bus.zeroE;
      default: branch_cond = 1'b0;
    endcase
    pc_src = ctrl_e_q.jump | (ctrl_e_q.branch & branch_cond);
  end

  always_comb begin
    d_uses_e  = (bus.RdE != 5'd0) && ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
    d_uses_m  = (bus.RdM != 5'd0) && ((bus.Rs1D == bus.RdM) || (bus.Rs2D == bus.RdM));
    lw_stall  = (ctrl_e_q.result_src == ResMem) && d_uses_e;
    // Without forwarding, producers in E and M must drain; W is covered by write-first RF.
    raw_stall = (ctrl_e_q.reg_write && d_uses_e) || (reg_write_m_q && d_uses_m);
    stall     = lw_stall || (!ENABLE_FORWARDING && raw_stall);
    flush_e   = stall || pc_src;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ENABLE_FORWARDING) begin
      if (reg_write_m_q && bus.RdM != 5'd0 && bus.Rs1E == bus.RdM) begin
        fwd_a = 2'b10;
      end else if (reg_write_w_q && bus.RdW != 5'd0 && bus.Rs1E == bus.RdW) begin
        fwd_a = 2'b01;
      end
      if (reg_write_m_q && bus.RdM != 5'd0 && bus.Rs2E == bus.RdM) begin
        fwd_b = 2'b10;
      end else if (reg_write_w_q && bus.RdW != 5'd0 && bus.Rs2E == bus.RdW) begin
        fwd_b = 2'b01;
      end
    end
  end

  always_comb begin
    ctrl_e_d       = flush_e ? '0 : dec;
    reg_write_m_d  = ctrl_e_q.reg_write;
    result_src_m_d = ctrl_e_q.result_src;
    mem_write_m_d  = ctrl_e_q.mem_write;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_e_q       <= '0;
      reg_write_m_q  <= 1'b0;
      result_src_m_q <= 2'b00;
      mem_write_m_q  <= 1'b0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
    end else begin
      ctrl_e_q       <= ctrl_e_d;
      reg_write_m_q  <= reg_write_m_d;
      result_src_m_q <= result_src_m_d;
      mem_write_m_q  <= mem_write_m_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
    end
  end

  always_comb begin
    bus.PCSrcE      = pc_src;
    bus.ImmSrcD     = dec_imm_src;
    bus.ALUSrcE     = ctrl_e_q.alu_src;
    bus.ALUControlE = ctrl_e_q.alu_control;
    bus.MemWriteM   = mem_write_m_q;
    bus.RegWriteW   = reg_write_w_q;
    bus.ResultSrcW  = result_src_w_q;
    bus.StallF      = stall;
    bus.StallD      = stall;
    bus.FlushD      = pc_src;
    bus.FlushE      = flush_e;
    bus.ForwardAE   = fwd_a;
    bus.ForwardBE   = fwd_b;
  end

endmodule

// File: tb/tb_pipelined_riscv_control_hazard.sv
// Randomized bench: two DUTs (forwarding on/off) share stimulus and are checked every cycle
// against an instruction-level pipeline model that tracks which instruction sits in E, M and W.
module tb_pipelined_riscv_control_hazard;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
  } instr_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipelined_riscv_control_hazard_if bus_f ();
  pipelined_riscv_control_hazard_if bus_n ();

  pipelined_riscv_control_hazard #(.ENABLE_FORWARDING(1'b1)) u_dut_fwd (
    .clock(clock),
    .reset(reset),
    .bus  (bus_f)
  );

  pipelined_riscv_control_hazard #(.ENABLE_FORWARDING(1'b0)) u_dut_nofwd (
    .clock(clock),
    .reset(reset),
    .bus  (bus_n)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Current stimulus
  instr_t     cur_d;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       zero_e;

  // Model: instruction held in each stage, per config (0 = forwarding, 1 = stall-only)
  instr_t e_i[2];
  instr_t m_i[2];
  instr_t w_i[2];
  bit     nxt_bubble[2];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes_rd(input logic [6:0] op);
    return (op == LW) || (op == RT) || (op == IA) || (op == JAL);
  endfunction

  function automatic logic [1:0] result_kind(input logic [6:0] op);
    if (op == LW)  return 2'b01;
    if (op == JAL) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] imm_kind(input logic [6:0] op);
    if (op == SW)  return 2'b01;
    if (op == BR)  return 2'b10;
    if (op == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_fn(input instr_t i);
    if (i.op == BR) return 3'b001;
    if (i.op != RT && i.op != IA) return 3'b000;
    if (i.f3 == 3'b111) return 3'b010;
    if (i.f3 == 3'b110) return 3'b011;
    if (i.f3 == 3'b010) return 3'b101;
    if (i.f3 == 3'b000 && i.op == RT && i.f7[5]) return 3'b001;
    return 3'b000;
  endfunction

  function automatic bit taken(input int c);
    if (e_i[c].op == JAL) return 1'b1;
    if (e_i[c].op != BR) return 1'b0;
    if (e_i[c].f3 == 3'b000) return zero_e;
    if (e_i[c].f3 == 3'b001) return !zero_e;
    return 1'b0;
  endfunction

  function automatic bit needs_stall(input int c);
    bit dep_e, dep_m;
    dep_e = (rde != 0) && (rs1d == rde || rs2d == rde);
    dep_m = (rdm != 0) && (rs1d == rdm || rs2d == rdm);
    if (e_i[c].op == LW && dep_e) return 1'b1;
    if (c == 0) return 1'b0;
    return (writes_rd(e_i[c].op) && dep_e) || (writes_rd(m_i[c].op) && dep_m);
  endfunction

  function automatic logic [1:0] fwd_src(input int c, input logic [4:0] rs);
    if (c == 1) return 2'b00;
    if (writes_rd(m_i[c].op) && rdm != 0 && rs == rdm) return 2'b10;
    if (writes_rd(w_i[c].op) && rdw != 0 && rs == rdw) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      e_i[c] = '0;
      m_i[c] = '0;
      w_i[c] = '0;
    end
  endtask

  task automatic drive();
    bus_f.opcode = cur_d.op;  bus_n.opcode = cur_d.op;
    bus_f.func3  = cur_d.f3;  bus_n.func3  = cur_d.f3;
    bus_f.func7  = cur_d.f7;  bus_n.func7  = cur_d.f7;
    bus_f.zeroE  = zero_e;    bus_n.zeroE  = zero_e;
    bus_f.Rs1D   = rs1d;      bus_n.Rs1D   = rs1d;
    bus_f.Rs2D   = rs2d;      bus_n.Rs2D   = rs2d;
    bus_f.Rs1E   = rs1e;      bus_n.Rs1E   = rs1e;
    bus_f.Rs2E   = rs2e;      bus_n.Rs2E   = rs2e;
    bus_f.RdE    = rde;       bus_n.RdE    = rde;
    bus_f.RdM    = rdm;       bus_n.RdM    = rdm;
    bus_f.RdW    = rdw;       bus_n.RdW    = rdw;
  endtask

  task automatic check_cfg(input int c, input string p,
                           input logic pcsrc, input logic [1:0] imm, input logic alusrc,
                           input logic [2:0] aluctl, input logic memw, input logic regw,
                           input logic [1:0] ressrc, input logic stf, input logic std,
                           input logic fd, input logic fe, input logic [1:0] fa,
                           input logic [1:0] fb);
    bit st, pc;
    st = needs_stall(c);
    pc = taken(c);
    check_eq({p, ".PCSrcE"}, pcsrc, pc);
    check_eq({p, ".ImmSrcD"}, imm, imm_kind(cur_d.op));
    check_eq({p, ".ALUSrcE"}, alusrc, (e_i[c].op == LW || e_i[c].op == SW || e_i[c].op == IA));
    check_eq({p, ".ALUControlE"}, aluctl, alu_fn(e_i[c]));
    check_eq({p, ".MemWriteM"}, memw, (m_i[c].op == SW));
    check_eq({p, ".RegWriteW"}, regw, writes_rd(w_i[c].op));
    check_eq({p, ".ResultSrcW"}, ressrc, result_kind(w_i[c].op));
    check_eq({p, ".StallF"}, stf, st);
    check_eq({p, ".StallD"}, std, st);
    check_eq({p, ".FlushD"}, fd, pc);
    check_eq({p, ".FlushE"}, fe, st | pc);
    check_eq({p, ".ForwardAE"}, fa, fwd_src(c, rs1e));
    check_eq({p, ".ForwardBE"}, fb, fwd_src(c, rs2e));
    nxt_bubble[c] = st | pc;
  endtask

  task automatic check_all();
    check_cfg(0, "fwd", bus_f.PCSrcE, bus_f.ImmSrcD, bus_f.ALUSrcE, bus_f.ALUControlE,
              bus_f.MemWriteM, bus_f.RegWriteW, bus_f.ResultSrcW, bus_f.StallF, bus_f.StallD,
              bus_f.FlushD, bus_f.FlushE, bus_f.ForwardAE, bus_f.ForwardBE);
    check_cfg(1, "nofwd", bus_n.PCSrcE, bus_n.ImmSrcD, bus_n.ALUSrcE, bus_n.ALUControlE,
              bus_n.MemWriteM, bus_n.RegWriteW, bus_n.ResultSrcW, bus_n.StallF, bus_n.StallD,
              bus_n.FlushD, bus_n.FlushE, bus_n.ForwardAE, bus_n.ForwardBE);
  endtask

  task automatic advance();
    for (int c = 0; c < 2; c++) begin
      w_i[c] = m_i[c];
      m_i[c] = e_i[c];
      e_i[c] = nxt_bubble[c] ? '0 : cur_d;
    end
  endtask

  task automatic randomize_inputs();
    logic [2:0] f3_pick [6];
    f3_pick = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100};
    case ($urandom_range(0, 7))
      0:       cur_d.op = LW;
      1:       cur_d.op = SW;
      2:       cur_d.op = RT;
      3:       cur_d.op = IA;
      4:       cur_d.op = BR;
      5:       cur_d.op = JAL;
      6:       cur_d.op = 7'($urandom);
      default: cur_d.op = 7'b0000000;
    endcase
    cur_d.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : f3_pick[$urandom_range(0, 5)];
    cur_d.f7 = 7'($urandom);
    zero_e   = 1'($urandom);
    rs1d = 5'($urandom_range(0, 3));
    rs2d = 5'($urandom_range(0, 3));
    rs1e = 5'($urandom_range(0, 3));
    rs2e = 5'($urandom_range(0, 3));
    rde  = 5'($urandom_range(0, 3));
    rdm  = 5'($urandom_range(0, 3));
    rdw  = 5'($urandom_range(0, 3));
  endtask

  initial begin
    cur_d = '{op: RT, f3: 3'b000, f7: 7'b0};
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
    zero_e = 1'b0;
    model_clear();
    drive();
    repeat (2) @(posedge clock);
    #2;
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      randomize_inputs();
      drive();
      if (cyc % 400 == 399) begin
        // Asynchronous reset in the middle of a cycle: registers must clear before the edge.
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check_eq("rst.RegWriteW", bus_f.RegWriteW, 1'b0);
        check_eq("rst.MemWriteM", bus_f.MemWriteM, 1'b0);
        check_eq("rst.PCSrcE", bus_f.PCSrcE, 1'b0);
        check_eq("rst.ForwardAE", bus_f.ForwardAE, 2'b00);
        check_eq("rst.StallF", bus_f.StallF, 1'b0);
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
      end else begin
        #2;
        check_all();
        @(posedge clock);
        advance();
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_riscv_control_hazard.md
Name: pipelined_riscv_control_hazard

Overview:
Companion block to the pipelined RISC-V datapath. It takes the datapath's status outputs and generates every control and hazard input that the datapath consumes.
- Status inputs: opcode, func3, func7, zeroE, and the register specifiers Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW.
- It decodes the instruction in the D stage and carries the control bits through its own D/E, E/M and M/W registers.
- It computes stall, flush, forwarding and branch-taken signals.
- Top level wires it beside the datapath; the two share clock and reset_pc.

Parameters:
ENABLE_FORWARDING, 1, 1 = ForwardAE/BE active; 0 = ForwardAE/BE tied 00 and every RAW hazard resolved by stalling.

Ports:
clock  input  1  clock, all flops rise on posedge
reset  input  1  asynchronous, active-high; clears all pipeline registers
opcode  input  7  D-stage instruction opcode
func3  input  3  D-stage func3
func7  input  7  D-stage func7
zeroE  input  1  ALU zero flag, E stage
Rs1D, Rs2D  input  5 each  D-stage source registers
Rs1E, Rs2E, RdE  input  5 each  E-stage registers
RdM  input  5  M-stage destination
RdW  input  5  W-stage destination
PCSrcE  output  1  take branch/jump target
ImmSrcD  output  2  00 I, 01 S, 10 B, 11 J
ALUSrcE  output  1  1 = immediate operand
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
MemWriteM  output  1  data memory write enable
RegWriteW  output  1  register file write enable
ResultSrcW  output  2  00 ALU, 01 memory, 10 PC+4
StallF, StallD  output  1 each  hold PC and IF/ID register
FlushD, FlushE  output  1 each  clear IF/ID and ID/EX registers
ForwardAE, ForwardBE  output  2 each  00 register file, 01 ResultW, 10 ALUResultM

Behaviour:
- D-stage decode is combinational from opcode:
  - 0000011 load: RegWrite=1, ImmSrc=00, ALUSrc=1, ResultSrc=01, add.
  - 0100011 store: MemWrite=1, ImmSrc=01, ALUSrc=1, add.
  - 0110011 R-type: RegWrite=1, ALUSrc=0, ResultSrc=00.
  - 0010011 I-ALU: RegWrite=1, ImmSrc=00, ALUSrc=1, ResultSrc=00.
  - 1100011 branch: Branch=1, ImmSrc=10, ALUSrc=0, sub.
  - 1101111 jal: Jump=1, RegWrite=1, ImmSrc=11, ResultSrc=10.
  - Any other opcode: all enables 0 (bubble); ImmSrcD=00.
- ALU op for R-type and I-ALU, by func3:
  - 000: sub only when opcode is R-type and func7[5]=1; otherwise add (addi never subtracts).
  - 111: and. 110: or. 010: slt.
  - Any other func3: add.
- D/E register holds RegWrite, ResultSrc, MemWrite, Jump, Branch, func3, ALUControl, ALUSrc.
  - Loads on every clock.
  - Cleared to 0 when FlushE=1; the flush wins over a new value.
- E/M register holds RegWrite, ResultSrc, MemWrite. M/W register holds RegWrite, ResultSrc. Neither is ever stalled or flushed.
- Control latency: a D-stage decode appears on the E outputs 1 cycle later, MemWriteM 2 cycles later, RegWriteW/ResultSrcW 3 cycles later.
- PCSrcE = JumpE | (BranchE & (func3E==000 ? zeroE : func3E==001 ? ~zeroE : 0)). Combinational.
- Forward A (Forward B identical using Rs2E):
  - 10 if RegWriteM & RdM!=0 & Rs1E==RdM;
  - else 01 if RegWriteW & RdW!=0 & Rs1E==RdW;
  - else 00.
  - M has priority over W.
- lwStall = (ResultSrcE==01) & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- With ENABLE_FORWARDING=0: stall = lwStall | (RegWriteE & RdE!=0 & D match RdE) | (RegWriteM & RdM!=0 & D match RdM). The W-stage hazard is covered by write-first register file behaviour.
- Hazard outputs:
  - StallF = StallD = stall.
  - FlushD = PCSrcE.
  - FlushE = stall | PCSrcE.
  - All combinational from current registers and inputs.
- Register x0: matches on register 0 never forward or stall.
- Reset (asynchronous, mid-operation allowed): every pipeline register goes to 0 immediately. All outputs are then 0 or 00, except ImmSrcD, which follows opcode.
- Simultaneous stall and PCSrcE: cannot occur with correct programs. If forced, all of StallF, StallD, FlushD and FlushE assert.

Test Plan:
- Reset asserted mid-stream → same cycle: RegWriteW=0, MemWriteM=0, PCSrcE=0, ForwardAE=00, StallF=0. After release, the first add reaches RegWriteW=1 three clocks after decode.
- add x3,x1,x2 followed by sub x4,x3,x5 → at sub's E stage ForwardAE=10; with an independent instruction between them, ForwardAE=01. ENABLE_FORWARDING=0: StallD asserted for 2 cycles instead.
- lw x5,0(x1) followed by add x6,x5,x7 → StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01.
- beq with zeroE=1 → PCSrcE=1, FlushD=1, FlushE=1 for 1 cycle. bne with zeroE=1 → PCSrcE=0.
- jal x1 → ImmSrcD=11, then PCSrcE=1 in E, ResultSrcW=10 and RegWriteW=1 two cycles later.
- add x0,x1,x2 followed by a use of x0 → ForwardAE=00, no stall. Opcode 0000000 → RegWriteW stays 0 and MemWriteM stays 0.
